prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk samples everything on its rising edge; port rst is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a load
- in_valid  in  1  upstream word valid
- in_data  in  16  upstream word
- in_ready  out  1  loader accepts in_data this cycle
- im_we  out  1  instruction memory write strobe
- im_addr  out  10  instruction memory write address
- im_data  out  16  instruction memory write data
- cpu_rst  out  1  reset to the CPU core; 1 holds the core in reset
- done  out  1  load finished; CPU released
- err  out  1  load failed; CPU held

Function
REQ-003 A word SHALL be accepted only in a cycle where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-004 The FSM SHALL have states IDLE, HDR, LOAD, CHK (only under the macro), RUN and ERR.
REQ-005 IDLE behaviour:
- in_ready=0, cpu_rst=1.
- start=1 -> HDR.
REQ-006 HDR behaviour:
- in_ready=1.
- On accept, length L=in_data[10:0].
- L=0 or L>1024 -> ERR.
- Otherwise store L, clear the write address to 0, go to LOAD.
REQ-007 LOAD behaviour:
- in_ready=1.
- Each accepted word SHALL produce exactly one write on the next cycle: im_we=1 for one cycle, im_addr = current address, im_data = the word.
- The address then increments by 1.
REQ-008 After the L-th payload word is accepted, the FSM SHALL go to CHK if the macro is defined, otherwise to RUN; in_ready SHALL be 0 in the cycle after the L-th accept.
REQ-009 L=1024 SHALL write addresses 0..1023 with no wrap; im_addr SHALL never exceed 1023.
REQ-010 RUN behaviour:
- cpu_rst=0, done=1, in_ready=0.
- Held until rst; start SHALL be ignored.
REQ-011 ERR behaviour:
- cpu_rst=1, err=1, in_ready=0.
- start=1 -> HDR, clearing err on that transition.
REQ-012 start SHALL be ignored in HDR, LOAD and CHK.
REQ-013 cpu_rst SHALL deassert in the same cycle done asserts, and not before the last im_we pulse has completed.
REQ-014 The throughput SHALL be one word per cycle when in_valid is held high.

Reset
REQ-015 When rst=1, the block SHALL on the next edge:
- go to IDLE;
- drive cpu_rst=1, in_ready=0, im_we=0, im_addr=0, im_data=0, done=0, err=0;
- clear the length and checksum registers.
REQ-016 rst during HDR, LOAD or CHK SHALL abort the load with no further im_we; words already written to IM are left in place.

Configuration
REQ-017 The macro PROG_LOADER_CHECKSUM_EN SHALL control the checksum feature.
- Defined:
  - A 16-bit wrap-around sum of the L payload words is accumulated.
  - CHK asserts in_ready=1 and accepts one checksum word.
  - If the word equals the sum -> RUN; otherwise -> ERR.
  - The checksum word is never written to IM.
- Not defined:
  - The CHK state and the sum register are absent.
  - LOAD goes directly to RUN.
  - err is raised only by an illegal length.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, start, header 3, words 0x1111/0x2222/0x3333 back-to-back -> writes (0,0x1111),(1,0x2222),(2,0x3333) on consecutive cycles; then (macro off) done=1 and cpu_rst=0.
- Header 0 or header 1025 -> err=1, cpu_rst=1, no im_we; then start -> back in HDR with err=0.
- Header 2 with in_valid toggling 1,0,1 -> exactly 2 writes at addresses 0 and 1; extra in_valid after the 2nd accept is not accepted (in_ready=0).
- Macro on, header 2, words 0xFFFF and 0x0002, checksum 0x0001 -> RUN; same with checksum 0x0000 -> err=1, cpu_rst=1.
- rst asserted after the 2nd of 5 words -> IDLE next cycle, im_we=0 thereafter, cpu_rst=1, done=0.
- Header 1024 -> last write at im_addr=1023, then done=1.

Source files
------------

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Boot loader that streams a program image into instruction memory and then
//   releases the CPU core from reset.
//
//   Stream format: one header word (length L = in_data[10:0], legal 1..1024),
//   followed by L payload words written to IM addresses 0..L-1. When the
//   optional checksum feature is built in (define PROG_LOADER_CHECKSUM_EN),
//   one more word follows: the 16-bit wrap-around sum of the payload. A match
//   releases the CPU; a mismatch raises err.
//
//   Ports:
//     clk       in   system clock (rising edge)
//     rst       in   synchronous active-high reset
//     start     in   one-cycle pulse that begins a load (from IDLE or ERR)
//     in_valid  in   upstream word valid
//     in_data   in   upstream word [15:0]
//     in_ready  out  loader accepts in_data this cycle
//     im_we     out  instruction memory write strobe
//     im_addr   out  instruction memory write address [9:0]
//     im_data   out  instruction memory write data [15:0]
//     cpu_rst   out  1 holds the CPU core in reset
//     done      out  load finished, CPU released
//     err       out  load failed, CPU held
// ---------------------------------------------------------------------------
module prog_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [9:0]  im_addr,
    output logic [15:0] im_data,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StHdr, StLoad, StChk, StRun, StErr} state_e;
`else
    typedef enum logic [2:0] {StIdle, StHdr, StLoad, StRun, StErr} state_e;
`endif

    state_e      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [10:0] cnt_q, cnt_d;
    logic [9:0]  addr_q, addr_d;
    logic        in_ready_q, in_ready_d;
    logic        im_we_q, im_we_d;
    logic [9:0]  im_addr_q, im_addr_d;
    logic [15:0] im_data_q, im_data_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;
`endif

    logic        accept;
    logic [10:0] hdr_len;
    logic        last_word;

    assign accept    = in_valid & in_ready_q;
    assign hdr_len   = in_data[10:0];
    assign last_word = (cnt_q + 11'd1) == len_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        im_we_d   = 1'b0;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StHdr;
            end
            StHdr: begin
                if (accept) begin
                    if (hdr_len == 11'd0 || hdr_len > 11'd1024) begin
                        state_d = StErr;
                    end else begin
                        len_d   = hdr_len;
                        cnt_d   = 11'd0;
                        addr_d  = 10'd0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum_d   = 16'd0;
`endif
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    im_we_d   = 1'b1;
                    im_addr_d = addr_q;
                    im_data_d = in_data;
                    // Wraps to 0 only after address 1023, when LOAD is being left anyway.
                    addr_d    = addr_q + 10'd1;
                    cnt_d     = cnt_q + 11'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d     = sum_q + in_data;
                    if (last_word) state_d = StChk;
`else
                    if (last_word) state_d = StRun;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            StChk: begin
                if (accept) state_d = (in_data == sum_q) ? StRun : StErr;
            end
`endif
            StRun: begin
                state_d = StRun;
            end
            StErr: begin
                if (start) state_d = StHdr;
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        in_ready_d = (state_d == StHdr) || (state_d == StLoad)
`ifdef PROG_LOADER_CHECKSUM_EN
                     || (state_d == StChk)
`endif
                     ;
        err_d      = (state_d == StErr);
        // Release lags entry into RUN by one cycle so the final im_we pulse has
        // already retired when the core comes out of reset.
        done_d     = (state_q == StRun);
        cpu_rst_d  = (state_q != StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            len_q      <= 11'd0;
            cnt_q      <= 11'd0;
            addr_q     <= 10'd0;
            in_ready_q <= 1'b0;
            im_we_q    <= 1'b0;
            im_addr_q  <= 10'd0;
            im_data_q  <= 16'd0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            in_ready_q <= in_ready_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_data_q  <= im_data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_data  = im_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader. Inputs change 1 ns after a rising edge and
//   outputs are sampled at the same point, so every check sees the registers
//   updated by the edge just taken. Checksum vectors are compiled only when
//   PROG_LOADER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        im_we;
    logic [9:0]  im_addr;
    logic [15:0] im_data;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Status outputs in one go: {in_ready, im_we, cpu_rst, done, err}.
    task automatic check_status(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, in_ready, im_we, cpu_rst, done, err}, {27'd0, exp});
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        tick();
        rst = 1'b0;
    endtask

    // Start pulse then a header word accepted on the following edge.
    task automatic send_start_hdr(input logic [15:0] hdr);
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = hdr;
        tick();
    endtask

    initial begin
        // ---- Reset state
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 16'hABCD;
        tick();
        tick();
        check_status("reset_status", 5'b00100);
        check("reset_addr", {22'd0, im_addr}, 32'd0);
        check("reset_data", {16'd0, im_data}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        tick();
        check_status("idle_no_start", 5'b00100);

        // ---- Header 3, three back-to-back words
        start = 1'b1;
        tick();
        check_status("hdr_ready", 5'b10100);
        send_start_hdr(16'd3);
        do_reset();
        send_start_hdr(16'd3);
        check_status("load_entered", 5'b10100);
        in_data = 16'h1111;
        tick();
        check_status("w0_we", 5'b11100);
        check("w0_addr", {22'd0, im_addr}, 32'd0);
        check("w0_data", {16'd0, im_data}, 32'h1111);
        in_data = 16'h2222;
        tick();
        check_status("w1_we", 5'b11100);
        check("w1_addr", {22'd0, im_addr}, 32'd1);
        check("w1_data", {16'd0, im_data}, 32'h2222);
        in_data = 16'h3333;
        tick();
        check("w2_addr", {22'd0, im_addr}, 32'd2);
        check("w2_data", {16'd0, im_data}, 32'h3333);
`ifdef PROG_LOADER_CHECKSUM_EN
        check_status("w2_we_chk", 5'b11100);
        in_data = 16'h6666;
        tick();
        check_status("chk_ok_no_write", 5'b00100);
`else
        check_status("w2_we_ready_low", 5'b01100);
`endif
        in_valid = 1'b0;
        tick();
        check_status("run_done", 5'b00010);
        start = 1'b1; in_valid = 1'b1;
        tick();
        tick();
        check_status("run_ignores_start", 5'b00010);

        // ---- Illegal headers
        do_reset();
        send_start_hdr(16'd0);
        check_status("hdr0_err", 5'b00101);
        in_valid = 1'b0;
        tick();
        check_status("hdr0_err_hold", 5'b00101);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_status("err_restart_hdr", 5'b10100);
        in_valid = 1'b1; in_data = 16'd1025;
        tick();
        check_status("hdr1025_err", 5'b00101);
        // Bits above [10:0] are not part of the length: 0xF802 means L=2.
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;

        // ---- Header 2 with in_valid 1,0,1 (upper header bits ignored)
        in_valid = 1'b1; in_data = 16'hF802;
        tick();
        check_status("hdr2_load", 5'b10100);
        in_data = 16'hAAAA;
        tick();
        check_status("gap_w0_we", 5'b11100);
        check("gap_w0_addr", {22'd0, im_addr}, 32'd0);
        in_valid = 1'b0; in_data = 16'hDEAD;
        tick();
        check_status("gap_idle_cycle", 5'b10100);
        in_valid = 1'b1; in_data = 16'hBBBB;
        tick();
        check("gap_w1_addr", {22'd0, im_addr}, 32'd1);
        check("gap_w1_data", {16'd0, im_data}, 32'hBBBB);
`ifdef PROG_LOADER_CHECKSUM_EN
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 16'h6665;
        tick();
        check_status("gap_chk_accept", 5'b00100);
        tick();
        check_status("gap_done", 5'b00010);
`else
        check_status("gap_w1_ready_low", 5'b01100);
        in_data = 16'hCCCC;
        tick();
        check_status("gap_extra_ignored", 5'b00010);
`endif

`ifdef PROG_LOADER_CHECKSUM_EN
        // ---- Checksum wraps: 0xFFFF + 0x0002 = 0x0001
        do_reset();
        send_start_hdr(16'd2);
        in_data = 16'hFFFF;
        tick();
        in_data = 16'h0002;
        tick();
        check_status("cs_w1_we", 5'b11100);
        in_data = 16'h0001;
        tick();
        check_status("cs_good_no_write", 5'b00100);
        in_valid = 1'b0;
        tick();
        check_status("cs_good_done", 5'b00010);
        do_reset();
        send_start_hdr(16'd2);
        in_data = 16'hFFFF;
        tick();
        in_data = 16'h0002;
        tick();
        in_data = 16'h0000;
        tick();
        check_status("cs_bad_err", 5'b00101);
        in_valid = 1'b0;
        tick();
        check_status("cs_bad_hold", 5'b00101);
`endif

        // ---- Reset mid-load after 2 of 5 words
        do_reset();
        send_start_hdr(16'd5);
        in_data = 16'h0A0A;
        tick();
        in_data = 16'h0B0B;
        tick();
        check("abort_w1_addr", {22'd0, im_addr}, 32'd1);
        rst = 1'b1; in_data = 16'h0C0C;
        tick();
        check_status("abort_reset", 5'b00100);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_status("abort_stays_idle", 5'b00100);
        end

        // ---- Header 1024: addresses 0..1023, no wrap
        do_reset();
        in_valid = 1'b0;
        send_start_hdr(16'd1024);
        for (int i = 0; i < 1024; i++) begin
            in_data = 16'(i ^ 16'h5A5A);
            tick();
            check("big_addr", {22'd0, im_addr}, 32'(i));
            check("big_data", {16'd0, im_data}, 32'(i ^ 16'h5A5A));
        end
        check("big_last_addr", {22'd0, im_addr}, 32'd1023);
`ifdef PROG_LOADER_CHECKSUM_EN
        check_status("big_last_we", 5'b11100);
        // Sum of i^0x5A5A over 0..1023 is 0x5A5A*(1024-... ) folded; compute in bench.
        begin
            logic [15:0] s;
            s = 16'd0;
            for (int i = 0; i < 1024; i++) s = s + 16'(i ^ 16'h5A5A);
            in_data = s;
        end
        tick();
        check_status("big_chk_accept", 5'b00100);
`else
        check_status("big_last_we", 5'b01100);
        in_valid = 1'b0;
`endif
        in_valid = 1'b0;
        tick();
        check_status("big_done", 5'b00010);
        check("big_addr_hold", {22'd0, im_addr}, 32'd1023);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
